// File: rtl/ula_pkg.sv
// Shared constants, state type and sizing helper for the multi-cycle 74181-style ALU.
package ula_pkg;

  // Function selects (74181 encoding); ULA_SUB and ULA_XOR share a code, M picks the meaning
  localparam logic [3:0] ULA_A    = 4'b0000;
  localparam logic [3:0] ULA_SUB  = 4'b0110;
  localparam logic [3:0] ULA_XOR  = 4'b0110;
  localparam logic [3:0] ULA_SOMA = 4'b1001;
  localparam logic [3:0] ULA_AND  = 4'b1011;
  localparam logic [3:0] ULA_OR   = 4'b1110;
  localparam logic [3:0] ULA_DEC  = 4'b1111;

  localparam logic MODO_LOGICO = 1'b0;
  localparam logic MODO_ARIT   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ula_multiciclo_if.sv
// Operand/result valid-ready bundle between the operand source, the ALU and the result sink.
interface ula_multiciclo_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       S;
  logic             M;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] F;
  logic             carry_out;
  logic             equal;
  logic             zero;

  modport master (
    output in_valid, A, B, S, M, carry_in, out_ready,
    input  in_ready, out_valid, F, carry_out, equal, zero
  );

  modport slave (
    input  in_valid, A, B, S, M, carry_in, out_ready,
    output in_ready, out_valid, F, carry_out, equal, zero
  );
endinterface

// File: rtl/ula_fatia.sv
// Combinational SLICE-bit slice with the 74181 active-high function table, carry active-high.
module ula_fatia
  import ula_pkg::*;
#(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic [3:0]       i_s,
  input  logic             i_m,
  input  logic             i_carry,
  output logic [SLICE-1:0] o_f,
  output logic             o_carry
);

  logic [SLICE-1:0] w_x;
  logic [SLICE-1:0] w_y;
  logic [SLICE:0]   w_soma;

  // Every arithmetic entry is X + Y + carry; the logic entry is ~(X ^ Y) with carries suppressed
  assign w_x = i_a | (i_b & {SLICE{i_s[0]}}) | (~i_b & {SLICE{i_s[1]}});
  assign w_y = (i_a & i_b & {SLICE{i_s[3]}}) | (i_a & ~i_b & {SLICE{i_s[2]}});

  assign w_soma = {1'b0, w_x} + {1'b0, w_y} + {{SLICE{1'b0}}, i_carry};

  always_comb begin
    o_f     = ~(w_x ^ w_y);
    o_carry = 1'b0;
    if (i_m == MODO_ARIT) begin
      o_f     = w_soma[SLICE-1:0];
      o_carry = w_soma[SLICE];
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle WIDTH-bit ALU: one SLICE-bit 74181 slice per clock, LSB first, carry chained.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  ula_multiciclo_if.slave io_ula
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned CNT_W = cnt_width(N);

  if ((SLICE == 0) || ((WIDTH % SLICE) != 0)) begin : g_largura_invalida
    $error("ula_multiciclo: WIDTH must be a non-zero multiple of SLICE");
  end

  estado_t          r_estado;
  estado_t          w_prox;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_f;
  logic [3:0]       r_s;
  logic             r_m;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cout;
  logic             r_equal;
  logic             r_zero;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_captura;
  logic             w_passo;
  logic             w_ultimo;
  logic [SLICE-1:0] w_fatia_f;
  logic             w_fatia_carry;
  logic [WIDTH+SLICE-1:0] w_f_concat;
  logic [WIDTH-1:0] w_f_desl;

  assign w_ultimo = (r_cnt == CNT_W'(N - 1));

  ula_fatia #(
    .SLICE (SLICE)
  ) u_fatia (
    .i_a     (r_a[SLICE-1:0]),
    .i_b     (r_b[SLICE-1:0]),
    .i_s     (r_s),
    .i_m     (r_m),
    .i_carry (r_carry),
    .o_f     (w_fatia_f),
    .o_carry (w_fatia_carry)
  );

  // New slice enters at the top; after N steps slice 0 has reached bit 0
  assign w_f_concat = {w_fatia_f, r_f};
  assign w_f_desl   = w_f_concat[WIDTH+SLICE-1:SLICE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox      = r_estado;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_captura   = 1'b0;
    w_passo     = 1'b0;
    unique case (r_estado)
      IDLE: begin
        w_in_ready = 1'b1;
        if (io_ula.in_valid) begin
          w_captura = 1'b1;
          w_prox    = RUN;
        end
      end
      RUN: begin
        w_passo = 1'b1;
        if (w_ultimo) w_prox = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = io_ula.out_ready;
        if (io_ula.out_ready) begin
          if (io_ula.in_valid) begin
            w_captura = 1'b1;
            w_prox    = RUN;
          end else begin
            w_prox = IDLE;
          end
        end
      end
      default: w_prox = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_f     <= '0;
      r_s     <= '0;
      r_m     <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
      r_equal <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_captura) begin
      r_a     <= io_ula.A;
      r_b     <= io_ula.B;
      r_s     <= io_ula.S;
      r_m     <= io_ula.M;
      r_carry <= (io_ula.M == MODO_ARIT) ? io_ula.carry_in : 1'b0;
      r_cnt   <= '0;
    end else if (w_passo) begin
      r_a     <= r_a >> SLICE;
      r_b     <= r_b >> SLICE;
      r_f     <= w_f_desl;
      r_carry <= w_fatia_carry;
      r_cnt   <= w_ultimo ? '0 : r_cnt + CNT_W'(1);
      if (w_ultimo) begin
        r_cout  <= w_fatia_carry;
        r_equal <= &w_f_desl;
        r_zero  <= ~|w_f_desl;
      end
    end
  end

  assign io_ula.in_ready  = w_in_ready;
  assign io_ula.out_valid = w_out_valid;
  assign io_ula.F         = r_f;
  assign io_ula.carry_out = r_cout;
  assign io_ula.equal     = r_equal;
  assign io_ula.zero      = r_zero;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed-vector bench for ula_multiciclo with hand-computed expected results.
module tb_ula_multiciclo;
  import ula_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  ula_multiciclo_if #(.WIDTH(16)) bus ();

  ula_multiciclo #(
    .WIDTH (16),
    .SLICE (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_ula (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT able to accept; returns at the negedge after acceptance
  task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          input logic m, input logic cin);
    bus.A        = a;
    bus.B        = b;
    bus.S        = s;
    bus.M        = m;
    bus.carry_in = cin;
    bus.in_valid = 1'b1;
    #1;
    chk("in_ready_before_accept", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = 16'($urandom);
    bus.B         = 16'($urandom);
    bus.S         = 4'($urandom);
    bus.M         = 1'($urandom);
    bus.carry_in  = 1'($urandom);
    #1;
    chk("run_out_valid", bus.out_valid, 0);
    chk("run_in_ready", bus.in_ready, 0);
  endtask

  task automatic expect_result(input string tag, input logic [15:0] f, input logic co,
                               input logic eq, input logic z);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_F"}, bus.F, f);
    chk({tag, "_carry_out"}, bus.carry_out, co);
    chk({tag, "_equal"}, bus.equal, eq);
    chk({tag, "_zero"}, bus.zero, z);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    chk("release_out_valid", bus.out_valid, 0);
    chk("release_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_valid;
    n_vec         = 0;
    n_miss        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.S         = '0;
    bus.M         = 1'b0;
    bus.carry_in  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_F", bus.F, 0);
    chk("reset_flags", {bus.carry_out, bus.equal, bus.zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);

    // Addition, then backpressure with a back-to-back logic op
    drive_op(16'h1234, 16'h0FFF, ULA_SOMA, MODO_ARIT, 1'b0);
    expect_result("add", 16'h2233, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_F", bus.F, 16'h2233);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_out_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    drive_op(16'hF0F0, 16'hFF00, ULA_XOR, MODO_LOGICO, 1'b1);
    expect_result("xor", 16'h0FF0, 1'b0, 1'b0, 1'b0);
    release_out();

    drive_op(16'hFFFF, 16'h0001, ULA_SOMA, MODO_ARIT, 1'b0);
    expect_result("wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
    release_out();

    drive_op(16'h5A5A, 16'h5A5A, ULA_SUB, MODO_ARIT, 1'b1);
    expect_result("cmp_c1", 16'h0000, 1'b1, 1'b0, 1'b1);
    release_out();

    drive_op(16'hF0F0, 16'hFF00, ULA_AND, MODO_LOGICO, 1'b0);
    expect_result("and", 16'hF000, 1'b0, 1'b0, 1'b0);
    release_out();

    drive_op(16'hFFFF, 16'h1234, ULA_A, MODO_ARIT, 1'b1);
    expect_result("inc", 16'h0000, 1'b1, 1'b0, 1'b1);
    release_out();

    drive_op(16'h0000, 16'h00AA, ULA_DEC, MODO_ARIT, 1'b0);
    expect_result("dec", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    release_out();

    drive_op(16'h00FF, 16'h0F0F, ULA_OR, MODO_LOGICO, 1'b0);
    expect_result("or", 16'h0FFF, 1'b0, 1'b0, 1'b0);
    release_out();

    // Comparison result held in DONE, then asynchronous reset mid-cycle
    drive_op(16'h5A5A, 16'h5A5A, ULA_SUB, MODO_ARIT, 1'b0);
    expect_result("cmp_c0", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_F", bus.F, 0);
    chk("async_rst_flags", {bus.carry_out, bus.equal, bus.zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    // Reset pulse during RUN aborts with no result
    drive_op(16'h1111, 16'h2222, ULA_SOMA, MODO_ARIT, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen_valid = seen_valid | bus.out_valid;
    end
    chk("abort_no_out_valid", seen_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ula_multiciclo.md
Name:
ula_multiciclo

Overview:
- Parametrised, multi-cycle successor to the 4-bit ula_74181.
- Accepts WIDTH-bit operands through a valid/ready handshake and processes them one SLICE-bit slice per clock, LSB slice first, through a single 74181-equivalent slice.
- Carry is chained between slices in a register; F, carry_out, equal and zero are held registered until the consumer accepts them.
- Sits between an operand source (register file or sequencer) and a result sink, both using valid/ready.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SLICE, otherwise elaboration error.
- SLICE, 4, bits processed per cycle; 4 matches one 74181 slice.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept an operand set.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- S  input  4  function select, 74181 encoding.
- M  input  1  mode: 0 = logic, 1 = arithmetic.
- carry_in  input  1  active-high carry into the LSB slice (1 = add one).
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer accepts the result.
- F  output  WIDTH  result.
- carry_out  output  1  carry out of the MSB slice.
- equal  output  1  all F bits are 1 (74181 A=B convention).
- zero  output  1  all F bits are 0.

Behaviour:
- Function table is the 74181 active-high data table, with carry_in active-high.
  - Example: S=1001, M=1 gives F = A plus B plus carry_in.
  - Example: S=0110, M=1 gives F = A + ~B + carry_in.
- Logic mode (M=0):
  - F is the bitwise function of A and B.
  - carry_in is ignored; carry_out = 0.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - F = 0, carry_out = 0, equal = 0, zero = 0, out_valid = 0.
  - Internal operand shift registers, carry register and slice counter cleared.
  - in_ready = 1 while in IDLE.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture A, B, S, M and carry_in (carry register = M ? carry_in : 0), set counter = 0, go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle:
    - Apply the low SLICE bits of the A/B shift registers and the carry register to ula_fatia.
    - Shift the slice result into the top of the F shift register.
    - Shift the operands right by SLICE.
    - Update the carry register; increment the counter.
  - After N = WIDTH/SLICE cycles, go to DONE.
  - The last slice's carry becomes carry_out.
  - equal and zero are computed from the complete F.
- DONE:
  - out_valid = 1.
  - F, carry_out, equal and zero are held stable while out_ready = 0.
  - in_ready = out_ready.
  - out_ready & in_valid: capture the new operands and go directly to RUN (no bubble).
  - out_ready & !in_valid: go to IDLE; out_valid falls.
- Latency: in_valid accepted at edge k gives out_valid high after edge k+N (N = 4 for defaults).
- Throughput: one result per N+1 cycles when out_ready is held high.
- Inputs A/B/S/M/carry_in may change freely once accepted; only the captured values are used.
- N = 1 (SLICE = WIDTH) is legal: a single RUN cycle.
- Counter width is clog2(N), minimum 1 bit; it wraps only through the RUN to DONE transition.
- Reset asserted during RUN or DONE aborts the operation with no result.

Decomposition:
- Package ula_pkg:
  - S encodings as named constants (e.g. ULA_SOMA = 4'b1001, ULA_SUB = 4'b0110, ULA_XOR = 4'b0110 in logic mode).
  - Mode constants MODO_LOGICO = 0, MODO_ARIT = 1.
  - State enum {IDLE, RUN, DONE}.
- Sub-module ula_fatia:
  - Combinational, parametrised SLICE-bit slice implementing the 74181 function table.
  - Inputs: A, B, S, M, carry_in. Outputs: F, carry_out.
- ula_multiciclo holds the FSM, shift registers, carry register, counter and flags.

Test Plan:
- Reset: assert rst_n = 0 asynchronously mid-cycle → immediately out_valid = 0, F = 0x0000, flags 0. After release, in_ready = 1.
- Addition: M=1, S=1001, A=0x1234, B=0x0FFF, carry_in=0 → 4 cycles later out_valid = 1, F = 0x2233, carry_out = 0, zero = 0.
- Wrap-around: M=1, S=1001, A=0xFFFF, B=0x0001, carry_in=0 → F = 0x0000, carry_out = 1, zero = 1, equal = 0.
- Comparison: M=1, S=0110, A=B=0x5A5A, carry_in=0 → F = 0xFFFF, equal = 1, carry_out = 0. Same with carry_in=1 → F = 0x0000, carry_out = 1, zero = 1.
- Logic mode: M=0, S=0110 (XOR), A=0xF0F0, B=0xFF00, carry_in=1 → F = 0x0FF0, carry_out = 0.
- Backpressure and reset abort:
  - Hold out_ready = 0 for 3 cycles in DONE → F stable, in_ready = 0.
  - Then out_ready = 1 with in_valid = 1 in the same cycle → new operation enters RUN next edge.
  - rst_n pulse during RUN → no out_valid is produced.
